// File: rtl/rv_core_pkg.sv
// Shared core types: register-file geometry and the write-back entry payload.
package rv_core_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_fifo.sv
// Circular buffer of write-back entries. Exposes every slot in age order
// (index 0 = head) with valid bits; data per slot only when BYPASS_EN is set.
module wb_fifo
   import rv_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push_i,
   input  logic [REG_AW-1:0]              push_rd_i,
   input  logic [XLEN-1:0]                push_data_i,
   input  logic                           pop_i,
   output logic                           empty_o,
   output logic                           full_o,
   output logic [XLEN-1:0]                head_data_o,
   output logic [DEPTH-1:0][REG_AW-1:0]   rd_o,
`ifdef BYPASS_EN
   output logic [DEPTH-1:0][XLEN-1:0]     data_o,
`endif
   output logic [DEPTH-1:0]               valid_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= '{rd: push_rd_i, data: push_data_i};
      end
   end

   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == CNT_W'(DEPTH));
   assign head_data_o = mem_q[rd_ptr_q].data;

   always_comb begin
      valid_o = '0;
      rd_o    = '0;
`ifdef BYPASS_EN
      data_o  = '0;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
         valid_o[k] = (count_q > CNT_W'(k));
         rd_o[k]    = mem_q[PTR_W'(rd_ptr_q + PTR_W'(k))].rd;
`ifdef BYPASS_EN
         data_o[k]  = mem_q[PTR_W'(rd_ptr_q + PTR_W'(k))].data;
`endif
      end
   end

endmodule

// File: rtl/reg_wb_queue.sv
// In-order write-back queue feeding the reg_file write port, with decode hazard
// detection. Define BYPASS_EN to forward the youngest matching entry instead of stalling.
module reg_wb_queue
   import rv_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [XLEN-1:0]   in_data,
   input  logic              hold,
   output logic              we3,
   output logic [REG_AW-1:0] a3,
   output logic [XLEN-1:0]   wd3,
   input  logic [REG_AW-1:0] q_a1,
   input  logic [REG_AW-1:0] q_a2,
   output logic              stall1,
   output logic              stall2,
   output logic              byp1_vld,
   output logic [XLEN-1:0]   byp1_data,
   output logic              byp2_vld,
   output logic [XLEN-1:0]   byp2_data
);

   logic                          push;
   logic                          empty;
   logic                          full;
   logic [XLEN-1:0]               head_data;
   logic [DEPTH-1:0][REG_AW-1:0]  ent_rd;
   logic [DEPTH-1:0]              ent_vld;
   logic [DEPTH-1:0]              hit1;
   logic [DEPTH-1:0]              hit2;
`ifdef BYPASS_EN
   logic [DEPTH-1:0][XLEN-1:0]    ent_data;
`endif

   // x0 results complete the handshake but are never queued.
   assign in_ready = !full;
   assign push     = in_valid && !full && (in_rd != '0);
   assign we3      = !empty && !hold;
   assign a3       = we3 ? ent_rd[0] : '0;
   assign wd3      = we3 ? head_data : '0;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_rd_i   (in_rd),
      .push_data_i (in_data),
      .pop_i       (we3),
      .empty_o     (empty),
      .full_o      (full),
      .head_data_o (head_data),
      .rd_o        (ent_rd),
`ifdef BYPASS_EN
      .data_o      (ent_data),
`endif
      .valid_o     (ent_vld)
   );

   // Per-slot address match; the head being written this cycle still counts.
   always_comb begin
      hit1 = '0;
      hit2 = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         hit1[k] = ent_vld[k] && (q_a1 != '0) && (ent_rd[k] == q_a1);
         hit2[k] = ent_vld[k] && (q_a2 != '0) && (ent_rd[k] == q_a2);
      end
   end

`ifdef BYPASS_EN
   // Scan oldest to youngest so the youngest match wins.
   always_comb begin
      stall1    = 1'b0;
      stall2    = 1'b0;
      byp1_vld  = |hit1;
      byp2_vld  = |hit2;
      byp1_data = '0;
      byp2_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (hit1[k]) byp1_data = ent_data[k];
         if (hit2[k]) byp2_data = ent_data[k];
      end
   end
`else
   assign stall1    = |hit1;
   assign stall2    = |hit2;
   assign byp1_vld  = 1'b0;
   assign byp2_vld  = 1'b0;
   assign byp1_data = '0;
   assign byp2_data = '0;
`endif

endmodule
